pwm_decoder: RTL

PWM capture block: samples a single-bit PWM line and recovers the duty-cycle code that produced it. It is the receive side of the team's 4-bit, 2^W-cycle-period PWM generator. Typical use is a loopback check or reading back a dimmer level. One duty word is published per complete PWM period, and invalid or stuck waveforms are flagged.

---
 rtl/pwm_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pwm_decoder.sv
// pwm_decoder: recovers the duty code of a 2^W-clock-period PWM line, one word per period.
// Define PWM_DEC_SYNC_EN to pass pwm_in through a 2-flop synchronizer (asynchronous input).
module pwm_decoder #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pwm_in,
    output logic [W-1:0] duty,
    output logic         duty_valid,
    output logic         period_err
);
    localparam logic [W:0] P   = {1'b1, {W{1'b0}}};
    localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, HIGH, LOW, STUCK} state_t;

    state_t     state, state_nx;
    logic       pwm_s, pwm_d;
    logic [W:0] per_cnt, per_nx;
    logic [W:0] hi_cnt, hi_nx;
    logic [W:0] run_cnt, run_nx;
    logic       ovf, ovf_nx;
    logic [W-1:0] duty_nx;
    logic       valid_nx, err_nx;
    logic       rise, fall, lo_to, hi_to;

`ifdef PWM_DEC_SYNC_EN
    logic sync1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            pwm_s <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            pwm_s <= sync1;
        end
    end
`else
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_s <= 1'b0;
        else       pwm_s <= pwm_in;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pwm_d <= 1'b0;
        else       pwm_d <= pwm_s;
    end

    function automatic logic [W:0] sat_inc(input logic [W:0] x);
        return (x == P) ? P : x + ONE;
    endfunction

    assign rise   = pwm_s & ~pwm_d;
    assign fall   = ~pwm_s & pwm_d;
    assign run_nx = (pwm_s != pwm_d) ? ONE : sat_inc(run_cnt);
    assign lo_to  = (run_nx == P) && !pwm_s;
    assign hi_to  = (run_nx == P) && pwm_s;

    always_comb begin
        state_nx = state;
        per_nx   = per_cnt;
        hi_nx    = hi_cnt;
        ovf_nx   = ovf;
        duty_nx  = duty;
        valid_nx = 1'b0;
        err_nx   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    per_nx   = ONE;
                    hi_nx    = ONE;
                    ovf_nx   = 1'b0;
                    state_nx = HIGH;
                end else if (lo_to) begin
                    duty_nx  = '0;
                    valid_nx = 1'b1;
                end
            end
            HIGH: begin
                if (hi_to) begin
                    duty_nx  = '1;
                    err_nx   = 1'b1;
                    state_nx = STUCK;
                end else if (fall) begin
                    per_nx   = sat_inc(per_cnt);
                    state_nx = LOW;
                end else begin
                    per_nx = sat_inc(per_cnt);
                    hi_nx  = sat_inc(hi_cnt);
                end
            end
            LOW: begin
                if (rise) begin
                    // a window is good only if the rise lands exactly P samples after the last one
                    if (per_cnt == P && !ovf) begin
                        duty_nx  = hi_cnt[W-1:0];
                        valid_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                    per_nx   = ONE;
                    hi_nx    = ONE;
                    ovf_nx   = 1'b0;
                    state_nx = HIGH;
                end else if (lo_to) begin
                    duty_nx  = '0;
                    valid_nx = 1'b1;
                    state_nx = IDLE;
                end else if (per_cnt == P) begin
                    ovf_nx = 1'b1;
                end else begin
                    per_nx = per_cnt + ONE;
                end
            end
            STUCK: begin
                if (fall) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            per_cnt    <= '0;
            hi_cnt     <= '0;
            run_cnt    <= '0;
            ovf        <= 1'b0;
            duty       <= '0;
            duty_valid <= 1'b0;
            period_err <= 1'b0;
        end else begin
            state      <= state_nx;
            per_cnt    <= per_nx;
            hi_cnt     <= hi_nx;
            // clearing on a low timeout spaces the zero-duty reports one period apart
            run_cnt    <= lo_to ? '0 : run_nx;
            ovf        <= ovf_nx;
            duty       <= duty_nx;
            duty_valid <= valid_nx;
            period_err <= err_nx;
        end
    end
endmodule
